control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Microcoded control unit for the 8-bit SAP-1.5 datapath. A step counter (T-states) plus the
//  IR opcode produce the per-cycle control word: bus output enables, register loads, PC and RAM
//  strobes. It is the sole arbiter of the shared 8-bit bus and guarantees one driver per cycle.
//  Sits beside the IR/flags in computer; all datapath registers take their *_load/*_oe from it.
// PARAMETERS
//  NUM_STEPS  6  T-states per instruction slot (min 5); step counter width = $clog2(NUM_STEPS)
//  OPCODE_W   4  opcode width (IR[7:4])
// PORTS
//  clk        in   1         system clock, all state updates on posedge
//  reset      in   1         asynchronous, active-low; clears step/halted
//  opcode     in   OPCODE_W  IR upper nibble; valid from T2 (IR loads at end of T1)
//  flag_zero  in   1         registered Z flag from ALU flags register
//  flag_carry in   1         registered C flag
//  pc_oe, ir_oe, ram_oe, a_oe, alu_oe   out 1 each  bus drivers (ir_oe drives IR[3:0], zero-ext)
//  pc_inc, pc_load, mar_load, ir_load, ram_we, a_load, b_load, out_load, flags_load  out 1 each
//  alu_sub    out  1         ALU subtract select
//  step       out  $clog2(NUM_STEPS)  current T-state (debug/bench)
//  halted     out  1         high after HLT until reset
// BEHAVIOUR
//  Reset (reset==0, async): step=0, halted=0, every control output 0 while asserted. First posedge
//   after release executes T0. Reset mid-instruction abandons it; no partial loads after release.
//  Control outputs are combinational from {step, opcode, flags, halted}; valid in the same cycle.
//  Step: step<=step+1 each clk; step<=0 on the cycle after a step marked DONE or at NUM_STEPS-1.
//  Fetch (all opcodes): T0 pc_oe,mar_load | T1 ram_oe,ir_load,pc_inc.
//  Execute (T2..), DONE on the last listed step:
//   0 NOP: T2 DONE (no signals)
//   1 LDA: T2 ir_oe,mar_load | T3 ram_oe,a_load DONE
//   2 ADD: T2 ir_oe,mar_load | T3 ram_oe,b_load | T4 alu_oe,a_load,flags_load DONE
//   3 SUB: as ADD; alu_sub=1 during T3 and T4 (setup before flags_load)
//   4 STA: T2 ir_oe,mar_load | T3 a_oe,ram_we DONE
//   5 LDI: T2 ir_oe,a_load DONE
//   6 JMP: T2 ir_oe,pc_load DONE
//   7 JC : T2 if flag_carry: ir_oe,pc_load; else nothing; DONE either way
//   8 JZ : T2 same, gated by flag_zero
//   E OUT: T2 a_oe,out_load DONE
//   F HLT: T2 halted<=1 at clk edge; step held at T2 thereafter; all controls 0 while halted
//   9-D undefined: treated as NOP
//  Bus rule: at most one of {pc_oe,ir_oe,ram_oe,a_oe,alu_oe} high in any cycle (incl. reset/halt);
//   unlisted steps drive all-zero control word; no load without a driver except pc_inc/halt.
//  pc_inc and pc_load never both high. Flags sampled combinationally at T2 only.
//  Halted state exits only via reset; opcode changes while halted are ignored.
//  Instruction lengths: NOP/LDI/JMP/JC/JZ/OUT 3 cycles, LDA/STA 4, ADD/SUB 5.
// TESTING
//  1 Hold reset low 3 cycles, opcode=2 -> all controls 0, step=0, halted=0; release -> T0 pc_oe,
//    mar_load on first cycle.
//  2 opcode=5 (LDI): trace T0,T1,T2 signals exactly as table; step returns to 0 on 4th cycle.
//  3 opcode=3 (SUB): T4 shows alu_oe,a_load,flags_load,alu_sub=1; step 0 on cycle 6; alu_sub=0 in T0-T2.
//  4 opcode=8 with flag_zero=1 -> T2 ir_oe,pc_load; flag_zero=0 -> T2 all zero; both 3 cycles long.
//  5 opcode=F -> halted=1 after T2 edge, step frozen, controls 0 for 10 cycles with random opcode;
//    pulse reset low mid-halt -> halted=0, next cycle T0.
//  6 Sweep opcodes 0..F, all flag combos: assert bus-driver one-hot-or-zero every cycle and
//    pc_inc&pc_load never; assert reset low mid-ADD at T3 -> outputs 0 immediately, restart at T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Purpose : microcoded control unit for the SAP-1.5 datapath; step counter + opcode -> control word.
// Latency : control word is combinational from {step, opcode, flags, halted}; step advances each clk.
// Backpressure: none; the sequencer free-runs one T-state per clock and freezes only after HLT.
//
// Ports:
//   clk, reset (async, active-low)     clock and reset; reset clears step/halted and zeroes controls
//   opcode, flag_zero, flag_carry      IR upper nibble (valid from T2) and registered ALU flags
//   pc_oe/ir_oe/ram_oe/a_oe/alu_oe     bus drivers, at most one high per cycle
//   pc_inc ... flags_load, alu_sub     register loads, PC/RAM strobes, ALU subtract select
//   step, halted                       current T-state and sticky halt indicator
module control_sequencer #(
    parameter int NUM_STEPS = 6,
    parameter int OPCODE_W  = 4,
    localparam int STEP_W   = $clog2(NUM_STEPS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_zero,
    input  logic                flag_carry,
    output logic                pc_oe,
    output logic                ir_oe,
    output logic                ram_oe,
    output logic                a_oe,
    output logic                alu_oe,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ir_load,
    output logic                ram_we,
    output logic                a_load,
    output logic                b_load,
    output logic                out_load,
    output logic                flags_load,
    output logic                alu_sub,
    output logic [STEP_W-1:0]   step,
    output logic                halted
);

    localparam logic [STEP_W-1:0] STEP_T0   = STEP_W'(0);
    localparam logic [STEP_W-1:0] STEP_T1   = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_T2   = STEP_W'(2);
    localparam logic [STEP_W-1:0] STEP_T3   = STEP_W'(3);
    localparam logic [STEP_W-1:0] STEP_T4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

    logic              done;      // current step is the last one of this instruction
    logic              halt_set;  // HLT reached T2 this cycle
    logic [STEP_W-1:0] step_nxt;
    logic              halted_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step   <= '0;
            halted <= 1'b0;
        end else begin
            step   <= step_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        step_nxt   = step + STEP_W'(1);
        halted_nxt = halted;
        if (halted) begin
            step_nxt = step;
        end else if (halt_set) begin
            step_nxt   = step;
            halted_nxt = 1'b1;
        end else if (done || step == STEP_LAST) begin
            step_nxt = '0;
        end
    end

    // Control word decode. Gating on reset as well as halted keeps every
    // output low for the whole reset interval, not just after the next edge.
    always_comb begin
        pc_oe      = 1'b0;
        ir_oe      = 1'b0;
        ram_oe     = 1'b0;
        a_oe       = 1'b0;
        alu_oe     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_load   = 1'b0;
        ir_load    = 1'b0;
        ram_we     = 1'b0;
        a_load     = 1'b0;
        b_load     = 1'b0;
        out_load   = 1'b0;
        flags_load = 1'b0;
        alu_sub    = 1'b0;
        done       = 1'b0;
        halt_set   = 1'b0;
        if (reset && !halted) begin
            if (step == STEP_T0) begin
                pc_oe    = 1'b1;
                mar_load = 1'b1;
            end else if (step == STEP_T1) begin
                ram_oe  = 1'b1;
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end else begin
                case (opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                        if (step == STEP_T2) begin
                            ir_oe    = 1'b1;
                            mar_load = 1'b1;
                        end else if (step == STEP_T3) begin
                            if (opcode == OP_STA) begin
                                a_oe   = 1'b1;
                                ram_we = 1'b1;
                                done   = 1'b1;
                            end else begin
                                ram_oe  = 1'b1;
                                a_load  = (opcode == OP_LDA);
                                b_load  = (opcode != OP_LDA);
                                alu_sub = (opcode == OP_SUB);
                                done    = (opcode == OP_LDA);
                            end
                        end else if (step == STEP_T4) begin
                            alu_oe     = 1'b1;
                            a_load     = 1'b1;
                            flags_load = 1'b1;
                            alu_sub    = (opcode == OP_SUB);
                            done       = 1'b1;
                        end
                    end
                    OP_LDI: begin
                        ir_oe  = (step == STEP_T2);
                        a_load = (step == STEP_T2);
                        done   = (step == STEP_T2);
                    end
                    OP_JMP: begin
                        ir_oe   = (step == STEP_T2);
                        pc_load = (step == STEP_T2);
                        done    = (step == STEP_T2);
                    end
                    OP_JC, OP_JZ: begin
                        // Branch taken only when the selected flag is set at T2.
                        if (step == STEP_T2) begin
                            ir_oe   = (opcode == OP_JC) ? flag_carry : flag_zero;
                            pc_load = ir_oe;
                            done    = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        a_oe     = (step == STEP_T2);
                        out_load = (step == STEP_T2);
                        done     = (step == STEP_T2);
                    end
                    OP_HLT: begin
                        halt_set = (step == STEP_T2);
                    end
                    default: begin
                        // NOP and undefined opcodes retire after an empty T2.
                        done = (step == STEP_T2);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose : directed self-checking bench for control_sequencer.
// Latency : expects the control word in the same cycle as the step it decodes.
// Backpressure: none; stimulus advances one T-state per clock.
module tb_control_sequencer;

    localparam logic [14:0] PC_OE   = 15'h4000;
    localparam logic [14:0] IR_OE   = 15'h2000;
    localparam logic [14:0] RAM_OE  = 15'h1000;
    localparam logic [14:0] A_OE    = 15'h0800;
    localparam logic [14:0] ALU_OE  = 15'h0400;
    localparam logic [14:0] PC_INC  = 15'h0200;
    localparam logic [14:0] PC_LD   = 15'h0100;
    localparam logic [14:0] MAR_LD  = 15'h0080;
    localparam logic [14:0] IR_LD   = 15'h0040;
    localparam logic [14:0] RAM_WE  = 15'h0020;
    localparam logic [14:0] A_LD    = 15'h0010;
    localparam logic [14:0] B_LD    = 15'h0008;
    localparam logic [14:0] OUT_LD  = 15'h0004;
    localparam logic [14:0] FL_LD   = 15'h0002;
    localparam logic [14:0] ALU_SUB = 15'h0001;
    localparam logic [14:0] FETCH0  = PC_OE | MAR_LD;
    localparam logic [14:0] FETCH1  = RAM_OE | IR_LD | PC_INC;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       flag_zero;
    logic       flag_carry;
    logic       pc_oe, ir_oe, ram_oe, a_oe, alu_oe;
    logic       pc_inc, pc_load, mar_load, ir_load, ram_we;
    logic       a_load, b_load, out_load, flags_load, alu_sub;
    logic [2:0] step;
    logic       halted;
    logic [14:0] cw;
    logic [4:0]  drivers;

    assign cw = {pc_oe, ir_oe, ram_oe, a_oe, alu_oe, pc_inc, pc_load, mar_load,
                 ir_load, ram_we, a_load, b_load, out_load, flags_load, alu_sub};
    assign drivers = {pc_oe, ir_oe, ram_oe, a_oe, alu_oe};

    control_sequencer #(.NUM_STEPS(6), .OPCODE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .pc_oe(pc_oe), .ir_oe(ir_oe), .ram_oe(ram_oe), .a_oe(a_oe), .alu_oe(alu_oe),
        .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load), .ir_load(ir_load),
        .ram_we(ram_we), .a_load(a_load), .b_load(b_load), .out_load(out_load),
        .flags_load(flags_load), .alu_sub(alu_sub), .step(step), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one instruction from T0; caller is just after a posedge with step==0.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic zf,
                             input logic cf, input logic [14:0] e2, input logic [14:0] e3,
                             input logic [14:0] e4, input int len);
        logic [14:0] exp;
        opcode     = op;
        flag_zero  = zf;
        flag_carry = cf;
        for (int i = 0; i < len; i++) begin
            exp = (i == 0) ? FETCH0 : (i == 1) ? FETCH1 : (i == 2) ? e2 : (i == 3) ? e3 : e4;
            @(negedge clk);
            chk($sformatf("%s_cw_t%0d", tag, i), 32'(cw), 32'(exp));
            chk($sformatf("%s_step_t%0d", tag, i), 32'(step), 32'(i));
            @(posedge clk);
            #2;
        end
        #1;
        chk($sformatf("%s_wrap", tag), 32'(step), 32'(0));
    endtask

    function automatic int exp_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b0;
        opcode     = 4'h2;
        flag_zero  = 1'b0;
        flag_carry = 1'b0;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_cw", 32'(cw), 32'(0));
            chk("rst_step", 32'(step), 32'(0));
            chk("rst_halted", 32'(halted), 32'(0));
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        run_instr("add", 4'h2, 1'b0, 1'b0, IR_OE | MAR_LD, RAM_OE | B_LD,
                  ALU_OE | A_LD | FL_LD, 5);

        run_instr("ldi", 4'h5, 1'b0, 1'b0, IR_OE | A_LD, 15'h0, 15'h0, 3);
        run_instr("sub", 4'h3, 1'b0, 1'b0, IR_OE | MAR_LD, RAM_OE | B_LD | ALU_SUB,
                  ALU_OE | A_LD | FL_LD | ALU_SUB, 5);
        run_instr("lda", 4'h1, 1'b0, 1'b0, IR_OE | MAR_LD, RAM_OE | A_LD, 15'h0, 4);
        run_instr("sta", 4'h4, 1'b0, 1'b0, IR_OE | MAR_LD, A_OE | RAM_WE, 15'h0, 4);
        run_instr("jmp", 4'h6, 1'b0, 1'b0, IR_OE | PC_LD, 15'h0, 15'h0, 3);
        run_instr("out", 4'hE, 1'b0, 1'b0, A_OE | OUT_LD, 15'h0, 15'h0, 3);
        run_instr("nop", 4'h0, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0, 3);
        run_instr("undef_b", 4'hB, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0, 3);
        run_instr("jz_taken", 4'h8, 1'b1, 1'b0, IR_OE | PC_LD, 15'h0, 15'h0, 3);
        run_instr("jz_not", 4'h8, 1'b0, 1'b1, 15'h0, 15'h0, 15'h0, 3);
        run_instr("jc_taken", 4'h7, 1'b0, 1'b1, IR_OE | PC_LD, 15'h0, 15'h0, 3);
        run_instr("jc_not", 4'h7, 1'b1, 1'b0, 15'h0, 15'h0, 15'h0, 3);

        // Sweep all non-halting opcodes and flag combinations.
        for (int op = 0; op < 15; op++) begin
            for (int fl = 0; fl < 4; fl++) begin
                opcode     = 4'(op);
                flag_zero  = fl[0];
                flag_carry = fl[1];
                n = 0;
                do begin
                    @(negedge clk);
                    chk("bus_onehot", 32'($countones(drivers) <= 1), 32'(1));
                    chk("inc_and_load", 32'(pc_inc & pc_load), 32'(0));
                    @(posedge clk);
                    #2;
                    n++;
                end while (step != 3'd0 && n < 8);
                chk($sformatf("len_op%0h_fl%0d", op, fl), 32'(n), 32'(exp_len(4'(op))));
            end
        end

        // HLT: fetch, then frozen at T2 regardless of opcode/flags.
        opcode = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hlt_fetch_cw", 32'(cw), 32'((i == 0) ? FETCH0 : (i == 1) ? FETCH1 : 15'h0));
            chk("hlt_fetch_halted", 32'(halted), 32'(0));
            @(posedge clk);
            #2;
        end
        for (int i = 0; i < 10; i++) begin
            opcode     = 4'($urandom_range(0, 15));
            flag_zero  = 1'($urandom_range(0, 1));
            flag_carry = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_cw", 32'(cw), 32'(0));
            chk("halt_step", 32'(step), 32'(2));
            chk("halt_flag", 32'(halted), 32'(1));
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'(0));
        chk("halt_rst_step", 32'(step), 32'(0));
        chk("halt_rst_cw", 32'(cw), 32'(0));
        reset = 1'b1;
        run_instr("post_halt_ldi", 4'h5, 1'b0, 1'b0, IR_OE | A_LD, 15'h0, 15'h0, 3);

        // Reset asserted mid-ADD at T3.
        opcode = 4'h2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
        end
        chk("midadd_step", 32'(step), 32'(3));
        chk("midadd_cw", 32'(cw), 32'(RAM_OE | B_LD));
        reset = 1'b0;
        #1;
        chk("midadd_rst_cw", 32'(cw), 32'(0));
        chk("midadd_rst_step", 32'(step), 32'(0));
        reset = 1'b1;
        run_instr("restart_add", 4'h2, 1'b0, 1'b0, IR_OE | MAR_LD, RAM_OE | B_LD,
                  ALU_OE | A_LD | FL_LD, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
